// File: rtl/inst_mem_pkg.sv
// Shared types and defaults for the loadable instruction memory.
// Optional even-parity protection of stored words is enabled with INST_MEM_PARITY_EN.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned INST_A_DEFAULT = 10;
  localparam int unsigned INST_W_DEFAULT = 9;
  localparam logic [INST_W_DEFAULT-1:0] NOP_DEFAULT = 9'h000;

endpackage

// File: rtl/inst_mem_array.sv
// Single-port synchronous RAM with write enable and registered read.
// With INST_MEM_PARITY_EN it also registers the XOR syndrome of the word read.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int unsigned A  = INST_A_DEFAULT,
  parameter int unsigned DW = INST_W_DEFAULT
) (
  input  logic          clk,
  input  logic          we,
  input  logic [A-1:0]  addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
`ifdef INST_MEM_PARITY_EN
  ,
  output logic          rd_syn
`endif
);

  logic [DW-1:0] mem_q [2**A];
  logic [DW-1:0] rdata_q;

  // Contents are deliberately not reset; the loader defines them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

`ifdef INST_MEM_PARITY_EN
  logic syn_q;

  // Syndrome is computed before the read register so the error flag lines up with the data.
  always_ff @(posedge clk) begin
    syn_q <= ^mem_q[addr];
  end

  assign rd_syn = syn_q;
`endif

endmodule

// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: valid/ready program load, then 1-cycle registered fetch.
// Define INST_MEM_PARITY_EN to store an even-parity bit per word and expose ParityErr.
module inst_mem_loadable
  import inst_mem_pkg::*;
#(
  parameter int unsigned A        = INST_A_DEFAULT,
  parameter int unsigned W        = INST_W_DEFAULT,
  parameter logic [W-1:0] NOP_WORD = {W{1'b0}}
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         LoadStart,
  input  logic         LoadValid,
  output logic         LoadReady,
  input  logic [W-1:0] LoadData,
  input  logic         LoadLast,
  output logic         LoadErr,
  output logic [A:0]   ProgLen,
  output logic         Ready,
  input  logic [A-1:0] InstAddress,
  output logic [W-1:0] InstOut,
  output logic         AddrFault
`ifdef INST_MEM_PARITY_EN
  ,
  output logic         ParityErr
`endif
);

`ifdef INST_MEM_PARITY_EN
  localparam int unsigned DW = W + 1;
`else
  localparam int unsigned DW = W;
`endif

  localparam logic [A:0] PTR_ONE  = {{A{1'b0}}, 1'b1};
  localparam logic [A:0] LAST_IDX = {1'b0, {A{1'b1}}};
  localparam logic [A:0] FULL_LEN = {1'b1, {A{1'b0}}};

  state_e        state_q, state_d;
  logic [A:0]    wr_ptr_q, wr_ptr_d;
  logic [A:0]    prog_len_q, prog_len_d;
  logic          load_err_q, load_err_d;
  logic          ready_q, ready_d;
  logic          load_ready_q, load_ready_d;
  logic          fetch_ok_q, fetch_ok_d;
  logic          addr_fault_q, addr_fault_d;

  logic          mem_we_s;
  logic [A-1:0]  mem_addr_s;
  logic [DW-1:0] mem_wdata_s;
  logic [DW-1:0] mem_rdata_s;

`ifdef INST_MEM_PARITY_EN
  logic          mem_syn_s;
  assign mem_wdata_s = {^LoadData, LoadData};
`else
  assign mem_wdata_s = LoadData;
`endif

  // Next-state, pointer, length and fetch-qualifier logic.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    prog_len_d   = prog_len_q;
    load_err_d   = load_err_q;
    fetch_ok_d   = 1'b0;
    addr_fault_d = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = InstAddress;

    case (state_q)
      IDLE: begin
        if (LoadStart) begin
          state_d    = LOAD;
          wr_ptr_d   = {(A+1){1'b0}};
          prog_len_d = {(A+1){1'b0}};
          load_err_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        mem_addr_s = wr_ptr_q[A-1:0];
        if (LoadStart) begin
          // Restart wins over a coincident transfer, which is dropped.
          wr_ptr_d   = {(A+1){1'b0}};
          prog_len_d = {(A+1){1'b0}};
          load_err_d = 1'b0;
        end else if (LoadValid && load_ready_q) begin
          mem_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (LoadLast) begin
            prog_len_d = wr_ptr_q + PTR_ONE;
            state_d    = RUN;
          end else if (wr_ptr_q == LAST_IDX) begin
            prog_len_d = FULL_LEN;
            load_err_d = 1'b1;
            state_d    = RUN;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      RUN: begin
        if (LoadStart) begin
          state_d    = LOAD;
          wr_ptr_d   = {(A+1){1'b0}};
          prog_len_d = {(A+1){1'b0}};
          load_err_d = 1'b0;
        end else if ({1'b0, InstAddress} >= prog_len_q) begin
          addr_fault_d = 1'b1;
        end else begin
          fetch_ok_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d      = (state_d == RUN);
    load_ready_d = (state_d == LOAD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= {(A+1){1'b0}};
      prog_len_q   <= {(A+1){1'b0}};
      load_err_q   <= 1'b0;
      ready_q      <= 1'b0;
      load_ready_q <= 1'b0;
      fetch_ok_q   <= 1'b0;
      addr_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      prog_len_q   <= prog_len_d;
      load_err_q   <= load_err_d;
      ready_q      <= ready_d;
      load_ready_q <= load_ready_d;
      fetch_ok_q   <= fetch_ok_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  inst_mem_array #(
    .A  (A),
    .DW (DW)
  ) u_array (
    .clk   (Clk),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
`ifdef INST_MEM_PARITY_EN
    ,
    .rd_syn(mem_syn_s)
`endif
  );

  // RAM read data is already registered; the select is a registered qualifier.
  assign InstOut   = fetch_ok_q ? mem_rdata_s[W-1:0] : NOP_WORD;
  assign AddrFault = addr_fault_q;
  assign LoadReady = load_ready_q;
  assign LoadErr   = load_err_q;
  assign ProgLen   = prog_len_q;
  assign Ready     = ready_q;

`ifdef INST_MEM_PARITY_EN
  assign ParityErr = fetch_ok_q & mem_syn_s;
`endif

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Scoreboard bench for inst_mem_loadable: per-cycle expectations from a program-level model.
// With INST_MEM_PARITY_EN defined it also injects a stored-bit flip and checks ParityErr.
module tb_inst_mem_loadable;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       LoadStart = 1'b0;
  logic       LoadValid = 1'b0;
  logic       LoadReady;
  logic [8:0] LoadData = 9'h000;
  logic       LoadLast = 1'b0;
  logic       LoadErr;
  logic [10:0] ProgLen;
  logic       Ready;
  logic [9:0] InstAddress = 10'd0;
  logic [8:0] InstOut;
  logic       AddrFault;
`ifdef INST_MEM_PARITY_EN
  logic       ParityErr;
`endif

  inst_mem_loadable dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .LoadStart  (LoadStart),
    .LoadValid  (LoadValid),
    .LoadReady  (LoadReady),
    .LoadData   (LoadData),
    .LoadLast   (LoadLast),
    .LoadErr    (LoadErr),
    .ProgLen    (ProgLen),
    .Ready      (Ready),
    .InstAddress(InstAddress),
    .InstOut    (InstOut),
    .AddrFault  (AddrFault)
`ifdef INST_MEM_PARITY_EN
    ,
    .ParityErr  (ParityErr)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        ready;
    logic        lready;
    logic        err;
    logic [10:0] len;
    logic [8:0]  inst;
    logic        af;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Program-level reference model
  int         mode = 0;   // 0 idle, 1 loading, 2 running
  int         ptr  = 0;
  int         len  = 0;
  bit         err  = 1'b0;
  logic [8:0] mmem [1024];
  bit         corrupt [1024];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("Ready",     {31'd0, Ready},     {31'd0, e.ready});
      chk("LoadReady", {31'd0, LoadReady}, {31'd0, e.lready});
      chk("LoadErr",   {31'd0, LoadErr},   {31'd0, e.err});
      chk("ProgLen",   {21'd0, ProgLen},   {21'd0, e.len});
      chk("InstOut",   {23'd0, InstOut},   {23'd0, e.inst});
      chk("AddrFault", {31'd0, AddrFault}, {31'd0, e.af});
`ifdef INST_MEM_PARITY_EN
      chk("ParityErr", {31'd0, ParityErr}, {31'd0, e.perr});
`endif
    end
  end

  task automatic step(input bit rst, input bit ls, input bit lv, input logic [8:0] ld,
                      input bit ll, input int addr);
    exp_t e;
    @(negedge Clk);
    Reset_n     = ~rst;
    LoadStart   = ls;
    LoadValid   = lv;
    LoadData    = ld;
    LoadLast    = ll;
    InstAddress = addr[9:0];
    e.inst = 9'h000;
    e.af   = 1'b0;
    e.perr = 1'b0;
    if (rst) begin
      mode = 0; ptr = 0; len = 0; err = 1'b0;
    end else if (mode == 0) begin
      if (ls) begin mode = 1; ptr = 0; len = 0; err = 1'b0; end
    end else if (mode == 1) begin
      if (ls) begin
        ptr = 0; len = 0; err = 1'b0;
      end else if (lv) begin
        mmem[ptr] = ld;
        corrupt[ptr] = 1'b0;
        if (ll) begin
          len = ptr + 1; mode = 2;
        end else if (ptr == 1023) begin
          len = 1024; err = 1'b1; mode = 2;
        end
        ptr++;
      end
    end else begin
      if (ls) begin
        mode = 1; ptr = 0; len = 0; err = 1'b0;
      end else if (addr >= len) begin
        e.af = 1'b1;
      end else begin
        e.inst = mmem[addr];
        e.perr = corrupt[addr];
      end
    end
    e.ready  = (mode == 2);
    e.lready = (mode == 1);
    e.err    = err;
    e.len    = 11'(len);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int addr);
    step(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, addr);
  endtask

  task automatic word(input logic [8:0] d, input bit last);
    step(1'b0, 1'b0, 1'b1, d, last, int'($urandom_range(0, 1023)));
  endtask

  task automatic start();
    step(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, 0);
  endtask

  initial begin
    logic [8:0] prog4 [4];
    int         n;
    prog4[0] = 9'h101; prog4[1] = 9'h0C2; prog4[2] = 9'h1E3; prog4[3] = 9'h044;
    for (int i = 0; i < 1024; i++) corrupt[i] = 1'b0;

    step(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 9'h155, 1'b1, 3);
    idle(5);

    // Back-to-back 4-word program, then in-range and out-of-range fetches
    start();
    for (int i = 0; i < 4; i++) word(prog4[i], i == 3);
    for (int i = 0; i < 4; i++) idle(i);
    idle(4); idle(1023); idle(2);
    step(1'b0, 1'b0, 1'b1, 9'h0AA, 1'b1, 0);

    // Gapped load, restart coincident with a valid word, then a 2-word load
    start();
    word(9'h011, 1'b0); idle(0);
    word(9'h022, 1'b0); idle(0);
    step(1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 0);
    word(9'h033, 1'b0); idle(0); word(9'h044, 1'b1);
    idle(0); idle(1); idle(2); idle(3);

    // Reset in the middle of a load
    start();
    word(9'h123, 1'b0); word(9'h045, 1'b0);
    step(1'b1, 1'b0, 1'b1, 9'h067, 1'b0, 0);
    idle(0);

    // Full depth without Last: error, then full depth with Last on the final word
    start();
    for (int i = 0; i < 1024; i++) word(9'($urandom), 1'b0);
    idle(1023); idle(0); idle(512); idle(1023);
    start();
    for (int i = 0; i < 1024; i++) word(9'($urandom), i == 1023);
    idle(1023); idle(7);

    // Randomized programs, gaps, restarts and fetches
    for (int it = 0; it < 40; it++) begin
      start();
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0)
          step(1'b0, 1'b1, 1'b1, 9'($urandom), 1'b0, 0);
        repeat ($urandom_range(0, 2))
          step(1'b0, 1'b0, 1'b0, 9'($urandom), 1'($urandom), 0);
        word(9'($urandom), i == n - 1);
      end
      for (int f = 0; f < 16; f++) begin
        case ($urandom_range(0, 3))
          0: step(1'b0, 1'b0, 1'($urandom), 9'($urandom), 1'b0, n);
          1: step(1'b0, 1'b0, 1'($urandom), 9'($urandom), 1'b0, int'($urandom_range(0, 1023)));
          default: step(1'b0, 1'b0, 1'($urandom), 9'($urandom), 1'b0, int'($urandom_range(0, n - 1)));
        endcase
      end
    end

`ifdef INST_MEM_PARITY_EN
    start();
    word(9'h0F0, 1'b0); word(9'h00F, 1'b0); word(9'h155, 1'b1);
    idle(0);
    @(negedge Clk);
    dut.u_array.mem_q[1] = dut.u_array.mem_q[1] ^ 10'h001;
    mmem[1] = mmem[1] ^ 9'h001;
    corrupt[1] = 1'b1;
    idle(1); idle(0); idle(2); idle(1);
`endif

    idle(0); idle(0);
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge Clk);
    @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
Parametrised, loadable instruction memory. It replaces the hard-coded case-table ROM with a RAM that is filled at run time over a valid/ready load port. It then serves instruction fetches to the decoder with one-cycle registered latency. It sits between the program loader/testbench and the program counter/decoder, and holds the core off (Ready=0) until a program is resident.

Parameters:
A, 10, instruction address width; depth = 2**A words
W, 9, instruction word width
NOP_WORD, 0 (W bits), value driven on InstOut when not in RUN or when the fetch address is out of range

Ports:
Clk  input  1  clock; all logic on rising edge
Reset_n  input  1  synchronous, active-low reset
LoadStart  input  1  single-cycle pulse; begin (or restart) a program load at address 0
LoadValid  input  1  LoadData is valid this cycle
LoadReady  output  1  block accepts a load word this cycle
LoadData  input  W  instruction word to store
LoadLast  input  1  qualifies LoadData as the final word of the program
LoadErr  output  1  sticky: load hit full depth without LoadLast
ProgLen  output  A+1  number of words in the resident program
Ready  output  1  program resident; fetches are valid
InstAddress  input  A  fetch address from program counter
InstOut  output  W  fetched instruction, registered
AddrFault  output  1  registered; fetch address was >= ProgLen

Behaviour:
- Clocking and reset: one clock, Clk. Reset_n is synchronous and active-low.
- Reset values: state IDLE, write pointer 0, ProgLen 0, Ready 0, LoadReady 0, LoadErr 0, InstOut NOP_WORD, AddrFault 0.
- Memory contents are not cleared by reset and are undefined until loaded.
- States: IDLE, LOAD, RUN.
- IDLE: LoadReady=0, Ready=0. LoadStart moves to LOAD.
- LOAD entry: WrPtr=0, LoadErr=0, ProgLen=0. Ready=0 and LoadReady=1 throughout LOAD.
- LOAD transfer: occurs when LoadValid && LoadReady. It writes LoadData to mem[WrPtr] and increments WrPtr.
- LOAD, transfer with LoadLast=1: ProgLen=WrPtr+1; next state RUN.
- LOAD, transfer at WrPtr=2**A-1 with LoadLast=0: word is written; ProgLen=2**A; LoadErr=1; next state RUN.
- LoadStart while in LOAD restarts the load: WrPtr=0, and any simultaneous transfer is discarded (not written).
- RUN: Ready=1, LoadReady=0. Each cycle InstAddress is sampled; on the next edge InstOut=mem[InstAddress] (latency 1 cycle).
- RUN, InstAddress >= ProgLen: InstOut=NOP_WORD and AddrFault=1 for that cycle. Otherwise AddrFault=0.
- RUN, LoadStart: enter LOAD next cycle (reload). Ready drops the same edge.
- Outside RUN: InstOut=NOP_WORD and AddrFault=0 every cycle.
- LoadValid without LoadReady: ignored and not written; the source must hold the word.
- Reset asserted mid-load: immediately returns to IDLE with the reset values above. Partially written words remain in the array but ProgLen=0.
- Width rules: WrPtr is A+1 bits so that a full-depth ProgLen is representable. The comparison against ProgLen is unsigned.

Optional Feature:
- Macro: INST_MEM_PARITY_EN.
- Defined: each stored word carries one extra even-parity bit, computed from LoadData at write. On each RUN fetch the parity is rechecked, and a registered output ParityErr (1 bit, reset 0) pulses for one cycle coincident with the faulty InstOut. InstOut is still driven with the stored data.
- Not defined: array is W bits wide and the ParityErr port does not exist.

Decomposition:
- Package inst_mem_pkg holds: the state enum (IDLE, LOAD, RUN) and a default NOP constant.
- Natural sub-module: inst_mem_array, a single-port synchronous RAM with write enable and registered read. Depth 2**A; width W, or W+1 with parity.
- Top level holds the FSM, pointer, ProgLen, fault and error logic.

Test Plan:
- Reset_n=0 for 2 cycles -> Ready=0, LoadReady=0, ProgLen=0, InstOut=0. Fetch at address 5 -> InstOut=0, AddrFault=0.
- LoadStart, then 4 words 9'h101, 9'h0C2, 9'h1E3, 9'h044 with Last on the 4th, back-to-back -> ProgLen=4 and Ready=1 on the edge after word 4. Fetch 0..3 -> those words, each 1 cycle later.
- Fetch address 4 and 1023 after the 4-word load -> InstOut=0, AddrFault=1. Fetch address 2 -> 9'h1E3, AddrFault=0.
- Gapped LoadValid (one idle cycle between words), then LoadStart mid-load coincident with a valid word -> that word not written, WrPtr=0. A subsequent 2-word load gives ProgLen=2.
- A=3, load 8 words with no LoadLast -> LoadErr=1, ProgLen=8, Ready=1. Next LoadStart clears LoadErr.
- With INST_MEM_PARITY_EN, force a bit flip in array word 1 and fetch 1 -> ParityErr=1 for exactly one cycle, InstOut = corrupted data.
